// File: rtl/qsys_system_data_mem_pkg.sv
// qsys_system_data_mem_pkg
// Shared definitions for the data-memory arbiter slice: memory geometry,
// the requester identifier and the read-tag record that travels alongside
// a read for one cycle.
package qsys_system_data_mem_pkg;

   localparam int DATA_MEM_DEPTH  = 6144;
   localparam int DATA_MEM_ADDR_W = 13;

   // Requester identity; CPU data master is m0, DFT/test DMA master is m1
   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_t;

   // One-cycle read tag: whether a read is returning, who owns it, and
   // whether it was an out-of-range read whose data must be forced to zero
   typedef struct packed {
      logic    valid;
      req_id_t id;
      logic    oor;
   } rd_tag_t;

endpackage

// File: rtl/qsys_system_data_mem_arb_rr_arb2.sv
// rr_arb2
// Two-input round-robin arbiter with a freeze input.
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   hold         when high no grant is issued
//   req[1:0]     request vector, bit 0 = CPU master, bit 1 = DMA master
//   grant[1:0]   one-hot grant, combinational from req, hold and rr_last
module rr_arb2
   import qsys_system_data_mem_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       hold,
   input  logic [1:0] req,
   output logic [1:0] grant
);

   req_id_t rr_last;

   // Grant decision: a lone requester always wins; on a tie the requester
   // that was not granted most recently wins, so neither master waits more
   // than one cycle while the other keeps requesting.
   always_comb begin
      grant = 2'b00;
      if (!hold) begin
         case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (rr_last == REQ_DMA) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
         endcase
      end
   end

   // Remember who was granted last; only an actual grant moves it. Reset
   // points it at the DMA master so the CPU wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last <= REQ_DMA;
      end else if (grant[0]) begin
         rr_last <= REQ_CPU;
      end else if (grant[1]) begin
         rr_last <= REQ_DMA;
      end
   end

endmodule

// File: rtl/qsys_system_data_mem_arb.sv
// qsys_system_data_mem_arb
// Shares the single-port on-chip data memory between the CPU data master
// (m0) and the DFT/test DMA master (m1). One access per cycle, round-robin
// on ties, one-cycle read latency, out-of-range accesses swallowed with an
// error pulse.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   hold                    blocks new grants
//   mN_address/byteenable/read/write/writedata   requester N command
//   mN_waitrequest          command not accepted this cycle
//   mN_readdata/readdatavalid  read return, one cycle after acceptance
//   mN_error                pulse the cycle after an out-of-range acceptance
//   mem_*                   memory s1 port (address registered, q unregistered)
module qsys_system_data_mem_arb
   import qsys_system_data_mem_pkg::*;
#(
   parameter int ADDR_W = DATA_MEM_ADDR_W,
   parameter int DATA_W = 32,
   parameter int DEPTH  = DATA_MEM_DEPTH
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                hold,

   input  logic [ADDR_W-1:0]   m0_address,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   output logic                m0_error,

   input  logic [ADDR_W-1:0]   m1_address,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic                m1_error,

   output logic [ADDR_W-1:0]   mem_address,
   output logic [DATA_W/8-1:0] mem_byteenable,
   output logic [DATA_W-1:0]   mem_writedata,
   output logic                mem_chipselect,
   output logic                mem_write,
   output logic                mem_clken,
   input  logic [DATA_W-1:0]   mem_readdata
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

   logic [1:0]        req;
   logic [1:0]        grant;
   logic              g_any;
   req_id_t           g_id;
   logic [ADDR_W-1:0] g_addr;
   logic [BE_W-1:0]   g_be;
   logic [DATA_W-1:0] g_wdata;
   logic              g_read;
   logic              g_write;
   logic              g_oor;
   logic              mem_go;
   rd_tag_t           tag_q;
   logic [1:0]        err_q;
   logic [DATA_W-1:0] rd_data;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   rr_arb2 u_rr_arb2 (
      .clk   (clk),
      .reset (reset),
      .hold  (hold),
      .req   (req),
      .grant (grant)
   );

   assign m0_waitrequest = req[0] & ~grant[0];
   assign m1_waitrequest = req[1] & ~grant[1];

   // Select the granted master's command. The range check is done one bit
   // wider so a DEPTH equal to 2**ADDR_W still compares correctly.
   always_comb begin
      g_any   = |grant;
      g_id    = grant[1] ? REQ_DMA : REQ_CPU;
      g_addr  = grant[1] ? m1_address    : m0_address;
      g_be    = grant[1] ? m1_byteenable : m0_byteenable;
      g_wdata = grant[1] ? m1_writedata  : m0_writedata;
      g_read  = grant[1] ? m1_read       : m0_read;
      g_write = grant[1] ? m1_write      : m0_write;
      g_oor   = ({1'b0, g_addr} >= DEPTH_EXT);
   end

   // Drive the memory only for an in-range grant; otherwise every memory
   // output sits at zero so an out-of-range write can never land anywhere.
   always_comb begin
      mem_go         = g_any & ~g_oor;
      mem_chipselect = mem_go;
      mem_write      = mem_go & g_write;
      mem_address    = mem_go ? g_addr  : '0;
      mem_byteenable = mem_go ? g_be    : '0;
      mem_writedata  = mem_go ? g_wdata : '0;
   end

   // Read tag follows each accepted read by one cycle, matching the memory's
   // registered address; error pulses are one cycle after an out-of-range
   // acceptance. Reset drops any read still in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_q.valid <= 1'b0;
         tag_q.id    <= REQ_CPU;
         tag_q.oor   <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         tag_q.valid <= g_any & g_read;
         tag_q.id    <= g_id;
         tag_q.oor   <= g_oor;
         err_q       <= grant & {2{g_oor}};
      end
   end

   // Steer the returning word to its owner; the other master sees zeros.
   // Out-of-range reads return zero rather than whatever the memory shows.
   always_comb begin
      rd_data          = tag_q.oor ? '0 : mem_readdata;
      m0_readdatavalid = tag_q.valid & (tag_q.id == REQ_CPU);
      m1_readdatavalid = tag_q.valid & (tag_q.id == REQ_DMA);
      m0_readdata      = m0_readdatavalid ? rd_data : '0;
      m1_readdata      = m1_readdatavalid ? rd_data : '0;
   end

   assign m0_error  = err_q[0];
   assign m1_error  = err_q[1];

   // Clock the memory off only when frozen and nothing is coming back.
   assign mem_clken = ~(hold & ~tag_q.valid);

endmodule

// File: tb/tb_qsys_system_data_mem_arb.sv
module tb_qsys_system_data_mem_arb;

   localparam int DEPTH = 6144;

   logic        clk = 1'b0;
   logic        reset;
   logic        hold;
   logic [12:0] m0_address, m1_address;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic        m0_error, m1_error;
   logic [12:0] mem_address;
   logic [3:0]  mem_byteenable;
   logic [31:0] mem_writedata;
   logic        mem_chipselect, mem_write, mem_clken;
   logic [31:0] mem_readdata;

   int checkCount = 0;
   int passCount  = 0;

   logic lastWait0, lastWait1, lastCs, lastClken;

   qsys_system_data_mem_arb dut (
      .clk              (clk),
      .reset            (reset),
      .hold             (hold),
      .m0_address       (m0_address),
      .m0_byteenable    (m0_byteenable),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m0_error         (m0_error),
      .m1_address       (m1_address),
      .m1_byteenable    (m1_byteenable),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .m1_error         (m1_error),
      .mem_address      (mem_address),
      .mem_byteenable   (mem_byteenable),
      .mem_writedata    (mem_writedata),
      .mem_chipselect   (mem_chipselect),
      .mem_write        (mem_write),
      .mem_clken        (mem_clken),
      .mem_readdata     (mem_readdata)
   );

   // Free-running 10-unit clock
   always #5 clk = ~clk;

   function automatic logic [31:0] mergeBytes(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end else begin
         passCount++;
      end
   endtask

   // Memory harness standing in for the on-chip RAM: registered address,
   // unregistered q, byte-lane writes; the index wraps so a stray access
   // beyond the end would alias onto low words and be noticed.
   logic [31:0] ram [0:DEPTH-1];
   logic [12:0] ramAddr = '0;
   int          ramIdx;

   assign mem_readdata = ram[ramAddr];

   always @(posedge clk) begin
      if (mem_clken && mem_chipselect) begin
         ramIdx = int'(mem_address) % DEPTH;
         if (mem_write) ram[ramIdx] <= mergeBytes(ram[ramIdx], mem_writedata, mem_byteenable);
         else ramAddr <= 13'(ramIdx);
      end
   end

   // Reference model: a transaction-level view of the arbiter. It decides
   // who is served this cycle from the request/hold rules, keeps its own copy
   // of memory contents, and remembers what must come back next cycle.
   logic [31:0] modelMem [0:DEPTH-1];
   int          rrLast = 1;
   logic        pendValid = 1'b0;
   int          pendId = 0;
   logic [31:0] pendData = '0;
   logic [1:0]  pendErr = 2'b00;
   logic        r0q, r1q;
   int          who;
   logic [12:0] gAddr;
   logic [3:0]  gBe;
   logic [31:0] gData;
   logic        gRead, gWrite, gOor, expCs;
   logic [31:0] expRd0, expRd1;

   // Single compare process: every falling edge, check all outputs against
   // the model, then advance the model by the transaction accepted this cycle.
   always @(negedge clk) begin
      r0q = m0_read | m0_write;
      r1q = m1_read | m1_write;
      who = -1;
      if (!hold) begin
         if (r0q && r1q) who = (rrLast == 1) ? 0 : 1;
         else if (r0q)   who = 0;
         else if (r1q)   who = 1;
      end
      gAddr  = (who == 1) ? m1_address    : m0_address;
      gBe    = (who == 1) ? m1_byteenable : m0_byteenable;
      gData  = (who == 1) ? m1_writedata  : m0_writedata;
      gRead  = (who == 1) ? m1_read       : m0_read;
      gWrite = (who == 1) ? m1_write      : m0_write;
      gOor   = int'(gAddr) >= DEPTH;
      expCs  = (who >= 0) && !gOor;

      if (reset) begin
         pendValid = 1'b0;
         pendErr   = 2'b00;
      end

      checkOutput("wait0", 32'(m0_waitrequest), 32'(r0q && who != 0));
      checkOutput("wait1", 32'(m1_waitrequest), 32'(r1q && who != 1));
      checkOutput("mem_cs", 32'(mem_chipselect), 32'(expCs));
      checkOutput("mem_we", 32'(mem_write), 32'(expCs && gWrite));
      if (expCs) begin
         checkOutput("mem_addr", 32'(mem_address), 32'(gAddr));
         checkOutput("mem_be", 32'(mem_byteenable), 32'(gBe));
         if (gWrite) checkOutput("mem_wd", mem_writedata, gData);
      end else if (who < 0) begin
         checkOutput("idle_addr", 32'(mem_address), 32'd0);
         checkOutput("idle_be", 32'(mem_byteenable), 32'd0);
         checkOutput("idle_wd", mem_writedata, 32'd0);
      end

      expRd0 = (pendValid && pendId == 0) ? pendData : 32'd0;
      expRd1 = (pendValid && pendId == 1) ? pendData : 32'd0;
      checkOutput("rdv0", 32'(m0_readdatavalid), 32'(pendValid && pendId == 0));
      checkOutput("rdv1", 32'(m1_readdatavalid), 32'(pendValid && pendId == 1));
      checkOutput("rd0", m0_readdata, expRd0);
      checkOutput("rd1", m1_readdata, expRd1);
      checkOutput("err0", 32'(m0_error), 32'(pendErr[0]));
      checkOutput("err1", 32'(m1_error), 32'(pendErr[1]));
      checkOutput("clken", 32'(mem_clken), 32'(!(hold && !pendValid)));

      if (!reset) begin
         pendValid = (who >= 0) && gRead;
         pendId    = who;
         pendData  = gOor ? 32'd0 : modelMem[int'(gAddr) % DEPTH];
         pendErr   = 2'b00;
         if (who >= 0 && gOor) pendErr[who] = 1'b1;
         if (expCs && gWrite) modelMem[gAddr] = mergeBytes(modelMem[gAddr], gData, gBe);
         if (who >= 0) rrLast = who;
      end else begin
         rrLast = 1;
      end
   end

   // Drive one cycle of requests starting just after a rising edge, sample
   // the combinational handshake mid-cycle, then return the masters to idle.
   task automatic applyStimulus(input logic r0, input logic w0, input logic [12:0] a0,
                                input logic [3:0] be0, input logic [31:0] d0,
                                input logic r1, input logic w1, input logic [12:0] a1,
                                input logic [3:0] be1, input logic [31:0] d1,
                                input logic h);
      m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
      m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
      hold = h;
      #2;
      lastWait0 = m0_waitrequest;
      lastWait1 = m1_waitrequest;
      lastCs    = mem_chipselect;
      lastClken = mem_clken;
      @(posedge clk);
      #1;
      m0_read = 1'b0; m0_write = 1'b0;
      m1_read = 1'b0; m1_write = 1'b0;
      hold = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         ram[i]      = '0;
         modelMem[i] = '0;
      end
      reset = 1'b1; hold = 1'b0;
      m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
      m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_rdv0", 32'(m0_readdatavalid), 32'd0);
      checkOutput("rst_err0", 32'(m0_error), 32'd0);
      checkOutput("rst_wait0", 32'(m0_waitrequest), 32'd0);
      checkOutput("rst_cs", 32'(mem_chipselect), 32'd0);
      checkOutput("rst_clken", 32'(mem_clken), 32'd1);
      reset = 1'b0;

      $display("[TB] write then read back on m0");
      applyStimulus(0, 1, 13'h10, 4'hF, 32'hA5A5_1234, 0, 0, 0, 0, 0, 0);
      checkOutput("wr_wait0", 32'(lastWait0), 32'd0);
      checkOutput("wr_cs", 32'(lastCs), 32'd1);
      applyStimulus(1, 0, 13'h10, 4'hF, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("rb_rdv0", 32'(m0_readdatavalid), 32'd1);
      checkOutput("rb_data0", m0_readdata, 32'hA5A5_1234);
      checkOutput("rb_rdv1", 32'(m1_readdatavalid), 32'd0);
      checkOutput("rb_data1", m1_readdata, 32'd0);

      $display("[TB] both masters reading continuously");
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 13'h11, 4'hF, 0, 0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 0, 13'h10, 4'hF, 0, 1, 0, 13'h11, 4'hF, 0, 0);
         checkOutput("alt_wait0", 32'(lastWait0), 32'(i % 2));
         checkOutput("alt_wait1", 32'(lastWait1), 32'((i + 1) % 2));
         checkOutput("alt_rdv0", 32'(m0_readdatavalid), 32'((i + 1) % 2));
         checkOutput("alt_rdv1", 32'(m1_readdatavalid), 32'(i % 2));
      end

      $display("[TB] partial write on m1 then immediate read on m0");
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 13'h20, 4'h3, 32'hFFFF_FFFF, 0);
      applyStimulus(1, 0, 13'h20, 4'hF, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("raw_wait0", 32'(lastWait0), 32'd0);
      checkOutput("raw_data0", m0_readdata, 32'h0000_FFFF);

      $display("[TB] out-of-range accesses");
      applyStimulus(0, 1, 13'd6144, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      checkOutput("oor_cs", 32'(lastCs), 32'd0);
      checkOutput("oor_wait0", 32'(lastWait0), 32'd0);
      checkOutput("oor_err_w", 32'(m0_error), 32'd1);
      applyStimulus(1, 0, 13'd6200, 4'hF, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("oor_err_r", 32'(m0_error), 32'd1);
      checkOutput("oor_rdv0", 32'(m0_readdatavalid), 32'd1);
      checkOutput("oor_data0", m0_readdata, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("oor_err_end", 32'(m0_error), 32'd0);
      checkOutput("oor_ram0", ram[0], 32'd0);

      $display("[TB] hold with both masters requesting");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 0, 13'h10, 4'hF, 0, 1, 0, 13'h11, 4'hF, 0, 1);
         checkOutput("hold_wait0", 32'(lastWait0), 32'd1);
         checkOutput("hold_wait1", 32'(lastWait1), 32'd1);
         checkOutput("hold_cs", 32'(lastCs), 32'd0);
         checkOutput("hold_clken", 32'(lastClken), 32'd0);
      end
      applyStimulus(1, 0, 13'h10, 4'hF, 0, 1, 0, 13'h11, 4'hF, 0, 0);
      checkOutput("rel_wait0", 32'(lastWait0), 32'd1);
      checkOutput("rel_wait1", 32'(lastWait1), 32'd0);

      $display("[TB] reset during an in-flight read");
      applyStimulus(1, 0, 13'h10, 4'hF, 0, 0, 0, 0, 0, 0, 0);
      reset = 1'b1;
      #1;
      checkOutput("rstfly_rdv0", 32'(m0_readdatavalid), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("rstfly_rdv0b", 32'(m0_readdatavalid), 32'd0);
      applyStimulus(1, 0, 13'h10, 4'hF, 0, 1, 0, 13'h11, 4'hF, 0, 0);
      checkOutput("rst_tie_wait0", 32'(lastWait0), 32'd0);
      checkOutput("rst_tie_wait1", 32'(lastWait1), 32'd1);
      checkOutput("rst_tie_data0", m0_readdata, 32'hA5A5_1234);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 400; i++) begin
         int c0, c1;
         logic [12:0] a0, a1;
         c0 = $urandom_range(0, 3);
         c1 = $urandom_range(0, 3);
         a0 = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(6144, 8191)) : 13'($urandom_range(0, 63));
         a1 = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(6144, 8191)) : 13'($urandom_range(0, 63));
         applyStimulus(c0 == 1, c0 == 2, a0, 4'($urandom_range(0, 15)), $urandom,
                       c1 == 1, c1 == 2, a1, 4'($urandom_range(0, 15)), $urandom,
                       $urandom_range(0, 7) == 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/qsys_system_data_mem_arb.md
# qsys_system_data_mem_arb

Two-requester Avalon-MM arbiter in front of the single-port 6144×32 on-chip data memory. It shares the memory between the CPU data master (m0) and the DFT/test DMA master (m1). Grants are round-robin with at most one access per cycle, reads are pipelined, and out-of-range accesses are blocked. It sits between the Qsys interconnect masters and the memory's s1 port, and drives that port's chipselect, write and clken.

## Interface
Parameters:
- ADDR_W, 13, word-address width of the memory.
- DATA_W, 32, data width; byteenable width = DATA_W/8.
- DEPTH, 6144, number of implemented words; addresses ≥ DEPTH are out of range.

Ports:
- clk  in  1  single clock for the block and the memory.
- reset  in  1  asynchronous, active-high reset.
- hold  in  1  freeze request; blocks new grants.
- mN_address  in  ADDR_W  requester N address (N = 0, 1).
- mN_byteenable  in  DATA_W/8  requester N byte lanes.
- mN_read, mN_write  in  1  requester N command; both high at once is illegal.
- mN_writedata  in  DATA_W  requester N write data.
- mN_waitrequest  out  1  command not accepted this cycle.
- mN_readdata  out  DATA_W  read return data.
- mN_readdatavalid  out  1  mN_readdata valid this cycle.
- mN_error  out  1  one-cycle pulse: out-of-range access was accepted and discarded.
- mem_address  out  ADDR_W  to memory.
- mem_byteenable  out  DATA_W/8  to memory.
- mem_writedata  out  DATA_W  to memory.
- mem_chipselect, mem_write  out  1  to memory.
- mem_clken  out  1  memory clock enable.
- mem_readdata  in  DATA_W  memory q (address registered, output unregistered).

## Operation
- Request: mN_read | mN_write.
- Grant:
  - Exactly one requester pending → that requester is granted.
  - Both pending → the one not granted last (rr_last) is granted.
  - rr_last updates only on a grant.
  - After reset, rr_last = m1, so m0 wins the first tie.
- hold = 1 → no grants; every pending mN_waitrequest = 1; the in-flight read still returns.
- mN_waitrequest = request_N & ~grant_N. It is 0 when idle.
- Granted in-range write: mem_chipselect = 1, mem_write = 1; address, byteenable and writedata passed through.
- Granted in-range read: mem_chipselect = 1, mem_write = 0; the requester ID is recorded in the read-tag register.
- Granted out-of-range access (address ≥ DEPTH):
  - Accepted (waitrequest = 0), but mem_chipselect = 0, so no write occurs.
  - mN_error pulses the following cycle.
  - A read also returns readdatavalid with readdata = 0 in that cycle.
- Read return:
  - rd_valid and rd_tag are registered.
  - The cycle after the grant, mTAG_readdatavalid = 1 and mTAG_readdata = mem_readdata (0 if out of range).
  - The non-tagged requester's readdata = 0.
- Back-to-back grants are allowed every cycle, including read-after-write to the same address. The memory write is committed at the grant edge, so the read returns the new data.
- mem_clken = 1 always, except while hold = 1 with no read returning.
- Idle memory outputs: chipselect = 0, write = 0, address = 0, byteenable = 0, writedata = 0.

## Timing
- Arbitration and waitrequest are combinational from requests, hold and rr_last, with no added stall cycle.
- Read latency: exactly 1 cycle from acceptance to readdatavalid. Throughput is 1 access/cycle total.
- Worst-case wait for a continuously requesting master: 1 cycle.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - rd_valid = 0, rr_last = m1, error pulses = 0.
  - All readdatavalid and error outputs = 0.
  - waitrequest follows its combinational equation.
- Reset during an in-flight read: the read is dropped, and no readdatavalid is issued after reset.
- Simultaneous grant to one master with a read return to the other: both happen in the same cycle.

## Structure
- Package qsys_system_data_mem_pkg holds:
  - constants DATA_MEM_DEPTH = 6144 and DATA_MEM_ADDR_W = 13;
  - the requester-ID type (REQ_CPU = 0, REQ_DMA = 1);
  - the read-tag struct {valid, id, oor}.
- Sub-module rr_arb2: two-input round-robin grant logic with the rr_last register, a hold input, and a one-hot grant output.
- The top level contains the mux, range check, read-tag pipeline and error pulses.

## Test plan
- Reset, then m0 writes 0xA5A5_1234 to address 0x10 with byteenable 0xF, then reads 0x10 → m0_readdatavalid 1 cycle after acceptance, data = 0xA5A5_1234, m1 outputs quiet.
- m0 and m1 both read continuously for 8 cycles → grants alternate m0, m1, m0, …, starting with m0; each waitrequest is high on alternate cycles; every return is tagged to the correct master.
- m1 writes 0xFFFF_FFFF with byteenable 0x3 to 0x20, then m0 immediately reads 0x20, with prior content 0 → read returns 0x0000_FFFF in the next cycle with no stall.
- m0 writes to address 6144 then reads 6200 → no mem_chipselect; m0_error pulses once per access; read returns readdatavalid with data 0; the memory at 0 is unchanged.
- hold = 1 for 3 cycles while both masters request → both waitrequest = 1 and no mem_chipselect; on release, the grant goes to the round-robin winner.
- Assert reset the cycle after an m0 read grant → no readdatavalid appears; after reset the first tie goes to m0.
